// File: rtl/mem_pkg.sv
// Shared memory-request types used by the request queue and the
// memory_controller command decode.
package mem_pkg;

    localparam int MEM_ADDR_W = 25;
    localparam int MEM_DATA_W = 16;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'b00,
        CMD_READ  = 2'b01,
        CMD_WRITE = 2'b10
    } mem_cmd_t;

    typedef struct packed {
        logic                  write;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_req_t;

    function automatic mem_cmd_t cmd_of(input logic write);
        return write ? CMD_WRITE : CMD_READ;
    endfunction

endpackage

// File: rtl/mem_req_fifo.sv
// Synchronous request FIFO with a head-of-queue view; the head stays
// visible until popped.
import mem_pkg::*;

module mem_req_fifo #(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  mem_req_t         push_data,
    input  logic             pop,
    output mem_req_t         head,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] cnt_q, cnt_d;
    mem_req_t         mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == LVL_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign level   = cnt_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (do_push && !do_pop) cnt_d = cnt_q + LVL_W'(1);
        if (do_pop && !do_push) cnt_d = cnt_q - LVL_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/mem_request_queue.sv
// Request queue in front of memory_controller: one command in flight.
// Optional WAIT timeout enabled by defining MEM_REQ_TIMEOUT_EN.
import mem_pkg::*;

module mem_request_queue #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 25,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [DATA_W-1:0]      req_wdata,
    output logic                   rsp_valid,
    output logic                   rsp_write,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   rsp_err,
    output logic [$clog2(DEPTH):0] level,
    output logic [1:0]             mc_cmd,
    output logic [ADDR_W-1:0]      mc_addr,
    output logic                   mc_ready,
    output logic [DATA_W-1:0]      mc_dq_out,
    output logic                   mc_dq_oe,
    input  logic [DATA_W-1:0]      mc_dq_in,
    input  logic                   mc_valid
);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT < 1)
        || (ADDR_W != MEM_ADDR_W) || (DATA_W != MEM_DATA_W)) begin : g_bad_param
        $error("mem_request_queue: unsupported parameters");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    mem_cmd_t          mc_cmd_q, mc_cmd_d;
    logic [ADDR_W-1:0] mc_addr_q, mc_addr_d;
    logic [DATA_W-1:0] mc_dq_out_q, mc_dq_out_d;
    logic              mc_ready_q, mc_ready_d;
    logic              mc_dq_oe_q, mc_dq_oe_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_write_q, rsp_write_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    mem_req_t          push_data;
    mem_req_t          head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic              to_hit;
    logic              in_write;

    assign push_data = '{write: req_write, addr: req_addr, wdata: req_wdata};
    assign req_ready = !fifo_full;

    mem_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (req_valid && req_ready),
        .push_data (push_data),
        .pop       (fifo_pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

`ifdef MEM_REQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;

    assign to_hit = (state_q == S_WAIT) && (to_cnt_q == CNT_W'(TIMEOUT));

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (state_q == S_ISSUE) begin
            to_cnt_d = '0;
        end else if (state_q == S_WAIT && !to_hit) begin
            to_cnt_d = to_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) to_cnt_q <= '0;
        else        to_cnt_q <= to_cnt_d;
    end
`else
    assign to_hit = 1'b0;
`endif

    assign in_write = (mc_cmd_q == CMD_WRITE);

    always_comb begin
        state_d     = state_q;
        mc_cmd_d    = mc_cmd_q;
        mc_addr_d   = mc_addr_q;
        mc_dq_out_d = mc_dq_out_q;
        mc_ready_d  = 1'b0;
        mc_dq_oe_d  = mc_dq_oe_q;
        rsp_valid_d = 1'b0;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        fifo_pop    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                mc_ready_d  = 1'b1;
                mc_cmd_d    = cmd_of(head.write);
                mc_addr_d   = head.addr;
                mc_dq_out_d = head.wdata;
                mc_dq_oe_d  = head.write;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                // Completion wins over a timeout landing on the same edge.
                if (mc_valid || to_hit) begin
                    fifo_pop    = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = in_write;
                    rsp_err_d   = !mc_valid;
                    rsp_rdata_d = (in_write || !mc_valid) ? '0 : mc_dq_in;
                    mc_cmd_d    = CMD_NONE;
                    mc_dq_oe_d  = 1'b0;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mc_cmd_q    <= CMD_NONE;
            mc_addr_q   <= '0;
            mc_dq_out_q <= '0;
            mc_ready_q  <= 1'b0;
            mc_dq_oe_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mc_cmd_q    <= mc_cmd_d;
            mc_addr_q   <= mc_addr_d;
            mc_dq_out_q <= mc_dq_out_d;
            mc_ready_q  <= mc_ready_d;
            mc_dq_oe_q  <= mc_dq_oe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign mc_cmd    = mc_cmd_q;
    assign mc_addr   = mc_addr_q;
    assign mc_dq_out = mc_dq_out_q;
    assign mc_ready  = mc_ready_q;
    assign mc_dq_oe  = mc_dq_oe_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_request_queue.sv
// Directed bench for mem_request_queue; the timeout section runs only
// when MEM_REQ_TIMEOUT_EN is defined.
module tb_mem_request_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [24:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_write;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic [2:0]  level;
    logic [1:0]  mc_cmd;
    logic [24:0] mc_addr;
    logic        mc_ready;
    logic [15:0] mc_dq_out;
    logic        mc_dq_oe;
    logic [15:0] mc_dq_in;
    logic        mc_valid;

    int total = 0;
    int fails = 0;

    always #10 clk = ~clk;

    mem_request_queue #(.DEPTH(4), .TIMEOUT(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_write (rsp_write),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .level     (level),
        .mc_cmd    (mc_cmd),
        .mc_addr   (mc_addr),
        .mc_ready  (mc_ready),
        .mc_dq_out (mc_dq_out),
        .mc_dq_oe  (mc_dq_oe),
        .mc_dq_in  (mc_dq_in),
        .mc_valid  (mc_valid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic w, input logic [24:0] a,
                           input logic [15:0] d);
        req_write = w;
        req_addr  = a;
        req_wdata = d;
    endtask

    // Ticks until mc_ready is seen, giving up after a fixed budget.
    task automatic wait_issue(input string tag, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (mc_ready) seen = 1'b1;
        end
        check(tag, {31'd0, seen}, 32'd1);
    endtask

    logic        seen;
    logic        stable;
    logic [24:0] fill_addr [5];

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b1;
        set_req(1'b1, 25'h123, 16'h5555);
        mc_dq_in  = '0;
        mc_valid  = 1'b0;
        for (int i = 0; i < 5; i++) fill_addr[i] = 25'h100 + 25'(i);

        repeat (3) tick();
        check("rst_level", 32'(level), 32'd0);
        check("rst_cmd", 32'(mc_cmd), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mc_ready", 32'(mc_ready), 32'd0);
        rst_n     = 1'b1;
        req_valid = 1'b0;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        tick();
        check("post_rst_level", 32'(level), 32'd0);

        // Write with minimum latency: push on N, strobe after N+2.
        req_valid = 1'b1;
        set_req(1'b1, 25'h0FFFF, 16'hAAAA);
        tick();
        req_valid = 1'b0;
        check("wr_level", 32'(level), 32'd1);
        tick();
        check("wr_no_early_ready", 32'(mc_ready), 32'd0);
        tick();
        check("wr_mc_ready", 32'(mc_ready), 32'd1);
        check("wr_mc_cmd", 32'(mc_cmd), 32'd2);
        check("wr_dq_oe", 32'(mc_dq_oe), 32'd1);
        check("wr_mc_addr", 32'(mc_addr), 32'h0FFFF);
        check("wr_dq_out", 32'(mc_dq_out), 32'hAAAA);
        stable = 1'b1;
        repeat (5) begin
            tick();
            if (mc_ready !== 1'b0 || mc_cmd !== 2'b10
                || mc_addr !== 25'h0FFFF || mc_dq_out !== 16'hAAAA
                || rsp_valid !== 1'b0) stable = 1'b0;
        end
        check("wr_wait_stable", 32'(stable), 32'd1);
        mc_valid = 1'b1;
        tick();
        mc_valid = 1'b0;
        check("wr_rsp_valid", 32'(rsp_valid), 32'd1);
        check("wr_rsp_write", 32'(rsp_write), 32'd1);
        check("wr_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("wr_rsp_err", 32'(rsp_err), 32'd0);
        check("wr_resp_cmd", 32'(mc_cmd), 32'd0);
        check("wr_resp_oe", 32'(mc_dq_oe), 32'd0);
        check("wr_pop_level", 32'(level), 32'd0);
        tick();
        check("wr_rsp_one_cycle", 32'(rsp_valid), 32'd0);

        // Read back the same address.
        req_valid = 1'b1;
        set_req(1'b0, 25'h0FFFF, 16'h0000);
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        check("rd_mc_ready", 32'(mc_ready), 32'd1);
        check("rd_mc_cmd", 32'(mc_cmd), 32'd1);
        check("rd_dq_oe", 32'(mc_dq_oe), 32'd0);
        tick();
        mc_dq_in = 16'hAAAA;
        mc_valid = 1'b1;
        tick();
        mc_valid = 1'b0;
        mc_dq_in = 16'h0000;
        check("rd_rsp_valid", 32'(rsp_valid), 32'd1);
        check("rd_rsp_rdata", 32'(rsp_rdata), 32'hAAAA);
        check("rd_rsp_write", 32'(rsp_write), 32'd0);
        tick();

        // Fill, stray mc_valid in IDLE, overflow held off.
        req_valid = 1'b1;
        set_req(1'b1, fill_addr[0], 16'h1000);
        tick();
        set_req(1'b0, fill_addr[1], 16'h1001);
        mc_valid = 1'b1;
        tick();
        mc_valid = 1'b0;
        check("stray_no_rsp", 32'(rsp_valid), 32'd0);
        check("stray_no_pop", 32'(level), 32'd2);
        set_req(1'b1, fill_addr[2], 16'h1002);
        tick();
        check("fill_issue", 32'(mc_ready), 32'd1);
        check("fill_head_addr", 32'(mc_addr), 32'(fill_addr[0]));
        set_req(1'b0, fill_addr[3], 16'h1003);
        tick();
        check("fill_level4", 32'(level), 32'd4);
        check("fill_not_ready", 32'(req_ready), 32'd0);
        set_req(1'b1, fill_addr[4], 16'h1004);
        tick();
        tick();
        check("ovf_held_level", 32'(level), 32'd4);
        mc_valid = 1'b1;
        tick();
        mc_valid = 1'b0;
        check("ovf_pop_no_push", 32'(level), 32'd3);
        check("ovf_rsp_valid", 32'(rsp_valid), 32'd1);
        check("ovf_rsp_write", 32'(rsp_write), 32'd1);
        check("ovf_ready_again", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        check("ovf_fifth_pushed", 32'(level), 32'd4);
        for (int i = 1; i < 5; i++) begin
            wait_issue($sformatf("drain%0d_issue", i), seen);
            if (!seen) break;
            check($sformatf("drain%0d_addr", i), 32'(mc_addr),
                  32'(fill_addr[i]));
            check($sformatf("drain%0d_cmd", i), 32'(mc_cmd),
                  (i % 2 == 0) ? 32'd2 : 32'd1);
            mc_valid = 1'b1;
            tick();
            mc_valid = 1'b0;
            check($sformatf("drain%0d_rsp", i), 32'(rsp_valid), 32'd1);
            tick();
        end
        check("drain_level", 32'(level), 32'd0);

        // Reset mid-WAIT abandons the command without a response.
        req_valid = 1'b1;
        set_req(1'b0, 25'h1ABCD, 16'h0000);
        tick();
        req_valid = 1'b0;
        wait_issue("mid_issue", seen);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_cmd", 32'(mc_cmd), 32'd0);
        stable = 1'b1;
        repeat (6) begin
            mc_valid = 1'b1;
            tick();
            if (rsp_valid !== 1'b0 || mc_ready !== 1'b0) stable = 1'b0;
        end
        mc_valid = 1'b0;
        check("mid_rst_quiet", 32'(stable), 32'd1);

`ifdef MEM_REQ_TIMEOUT_EN
        req_valid = 1'b1;
        set_req(1'b0, 25'h00AA, 16'h0000);
        tick();
        set_req(1'b1, 25'h00BB, 16'h7777);
        tick();
        req_valid = 1'b0;
        wait_issue("to_issue", seen);
        mc_dq_in = 16'hBEEF;
        stable = 1'b1;
        repeat (8) begin
            tick();
            if (rsp_valid !== 1'b0) stable = 1'b0;
        end
        check("to_no_early_rsp", 32'(stable), 32'd1);
        tick();
        check("to_rsp_valid", 32'(rsp_valid), 32'd1);
        check("to_rsp_err", 32'(rsp_err), 32'd1);
        check("to_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("to_popped", 32'(level), 32'd1);
        mc_dq_in = 16'h0000;
        wait_issue("to_next_issue", seen);
        check("to_next_addr", 32'(mc_addr), 32'h00BB);
        mc_valid = 1'b1;
        tick();
        mc_valid = 1'b0;
        check("to_next_rsp", 32'(rsp_valid), 32'd1);
        check("to_next_err", 32'(rsp_err), 32'd0);
        tick();
`endif

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/mem_request_queue.md
# mem_request_queue

Front-end request stage sitting directly upstream of `memory_controller`. Buffers read/write requests from a client in a small FIFO and issues them one at a time over the controller's one-hot `cmd`/`addr`/`dq`/`ready`/`valid` handshake. Returns one response per request: read data for reads, completion for writes. Serialises access so the controller never sees a new command before the previous one reports `valid`.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `ADDR_W`, 25: address width, matching the 512Mb SDRAM word space.
- `DATA_W`, 16: data width.
- `TIMEOUT`, 255: cycles to wait for `mc_valid`; used only with the timeout macro.

Ports:
- `clk` in 1: 50 MHz clock; all logic on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in 1: client request present.
- `req_ready` out 1: queue can accept; equals `!full`.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in ADDR_W: request address.
- `req_wdata` in DATA_W: write data.
- `rsp_valid` out 1: one-cycle response strobe.
- `rsp_write` out 1: type of the completed request.
- `rsp_rdata` out DATA_W: read data; 0 for writes.
- `rsp_err` out 1: response aborted by timeout.
- `level` out $clog2(DEPTH)+1: FIFO occupancy.
- `mc_cmd` out 2: 2'b10 = WRITE, 2'b01 = READ, 2'b00 = none.
- `mc_addr` out ADDR_W: address to the controller.
- `mc_ready` out 1: command strobe to the controller.
- `mc_dq_out` out DATA_W: write data.
- `mc_dq_oe` out 1: top level drives `dq` from `mc_dq_out` when 1.
- `mc_dq_in` in DATA_W: `dq` as seen from the controller.
- `mc_valid` in 1: controller reports the command has finished.

## Operation
- **Accept:** a request is accepted on any edge where `req_valid && req_ready`. It is pushed as {write, addr, wdata}.
- **Full FIFO:** `req_ready` = 0; no push occurs even if a pop happens in the same cycle.
- **FSM states:** IDLE, ISSUE, WAIT, RESP.
- **IDLE:** if the FIFO is non-empty, go to ISSUE; otherwise stay.
- **ISSUE:** lasts exactly one cycle.
  - `mc_ready` = 1.
  - `mc_cmd`, `mc_addr` and `mc_dq_out` come from the FIFO head.
  - `mc_dq_oe` = `write`.
  - Next state is WAIT.
- **WAIT:** all `mc_*` outputs are held stable and `mc_ready` = 0.
  - On `mc_valid` = 1: capture `mc_dq_in` into `rsp_rdata` (reads; 0 for writes), pop the head, go to RESP.
- **RESP:** `rsp_valid` = 1 for one cycle, then IDLE. `mc_cmd` = 00 and `mc_dq_oe` = 0.
- **`mc_valid` outside WAIT:** ignored.
- **Pointers and count:** wrap modulo DEPTH. Push and pop in the same cycle leave `level` unchanged.
- **Reset mid-operation:**
  - FIFO is emptied, FSM returns to IDLE, any in-flight command is abandoned with no response.
  - The controller shares `rst_n`.
- **Reset values:**
  - `req_ready` = 1.
  - `mc_cmd`, `mc_addr`, `mc_dq_out` = 0.
  - `mc_ready`, `mc_dq_oe` = 0.
  - `rsp_valid`, `rsp_write`, `rsp_err` = 0.
  - `rsp_rdata` = 0, `level` = 0.

## Timing
- All outputs are registered except `req_ready` and `level`, which are decoded from registered count.
- **Minimum latency (empty queue):** acceptance on edge N, IDLE at N+1, `mc_ready` high during the cycle after edge N+2.
- **Response:** `rsp_valid` is high in the cycle after the edge that samples `mc_valid` in WAIT.
- **Back-to-back requests:** the next ISSUE follows RESP → IDLE, giving a minimum 2 idle cycles between `mc_ready` strobes beyond the controller latency.
- **No response backpressure:** the client must accept `rsp_valid` whenever it is asserted.

## Configuration
- **`MEM_REQ_TIMEOUT_EN` defined:**
  - A counter runs in WAIT.
  - If TIMEOUT cycles elapse without `mc_valid`, the head is popped and the FSM goes to RESP.
  - The response carries `rsp_err` = 1 and `rsp_rdata` = 0.
  - The counter clears on ISSUE.
- **Not defined:** WAIT holds indefinitely, and `rsp_err` is tied to 0.

## Structure
- **Shared package `mem_pkg`:**
  - `mem_cmd_t` enum: CMD_NONE = 2'b00, CMD_READ = 2'b01, CMD_WRITE = 2'b10. The `memory_controller` decode uses the same enum.
  - `mem_req_t` struct {write, addr, wdata}.
  - Address and data width constants.
- **Local to this block:** the FSM state enum.
- **Sub-module `mem_req_fifo`:** synchronous FIFO parameterised by DEPTH and a `mem_req_t` payload. Outputs are push/pop/full/empty/level and a head-of-queue view.

## Test plan
- **Reset:** hold `rst_n` = 0 for 3 cycles with `req_valid` = 1 → no push, `level` = 0, `mc_cmd` = 00, `rsp_valid` = 0, `req_ready` = 1 after release.
- **Write then read, same address:**
  - Write `addr`=25'h0FFFF, `wdata`=16'hAAAA → one `mc_ready` strobe with `mc_cmd`=10, `mc_dq_oe`=1.
  - Model raises `mc_valid` 6 cycles later → `rsp_valid` with `rsp_write`=1.
  - Read the same address with model returning 16'hAAAA → `rsp_rdata`=16'hAAAA, `rsp_write`=0.
- **Fill and overflow:** push 5 requests with DEPTH=4 while the model withholds `mc_valid` → `req_ready`=0 after the 4th (4th goes to ISSUE, 4 queued incl. head), `level`=4, 5th held until a pop.
- **Stray `mc_valid`:** pulse `mc_valid` in IDLE → no pop, no `rsp_valid`.
- **Stability in WAIT:** `mc_addr`/`mc_cmd`/`mc_dq_out` constant from ISSUE until `mc_valid`.
- **With `MEM_REQ_TIMEOUT_EN`, TIMEOUT=8, model never responds:**
  - `rsp_valid` with `rsp_err`=1, 9 cycles after WAIT entry.
  - Next queued request is then issued normally.
